mcycle_maindec: RTL and testbench
=================================

# mcycle_maindec

Multi-cycle successor to the single-cycle MIPS main decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the per-cycle datapath controls: PC/IR write enables, mux selects, memory strobes, register write and ALU operation code. It sits between the instruction register and the shared multi-cycle datapath. It stalls on a memory ready handshake and flags illegal opcodes.

## Interface
- `ALUOP_W`, 8: width of `aluop`. Must be ≥ 8; codes are zero-extended to this width.
- `EN_JAL`, 1: when 1, decode `jal` (0x03); when 0, treat it as illegal.
- `EN_BNE`, 1: when 1, decode `bne` (0x05); when 0, treat it as illegal.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `op` in 6: opcode field of the instruction register. Valid from DECODE onwards.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pcwrite`, `irwrite`, `iord`, `memread`, `memwrite`, `regwrite` out 1 each: datapath strobes.
- `branch`, `branch_ne` out 1 each: conditional PC write on ALU zero / not-zero.
- `alusrca` out 1: ALU A select. 0 = PC, 1 = rs.
- `alusrcb` out 2: ALU B select. 00 = rt, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2.
- `ext_zero` out 1: 1 selects zero-extension of the immediate.
- `regdst` out 2: destination register. 00 = rt, 01 = rd, 10 = r31.
- `memtoreg` out 2: writeback source. 00 = ALUOut, 01 = MDR, 10 = PC.
- `pcsrc` out 2: next-PC source. 00 = ALU, 01 = ALUOut, 10 = jump target.
- `aluop` out ALUOP_W: ALU operation code.
- `illegal` out 1: one-cycle pulse on an undecodable opcode.
- `state` out 4: current state, for debug.

## Operation
- ALU codes:
  - ADD = 0x20, SUB = 0x22, RTYPE = 0x02.
  - addi 0x08, addiu 0x09, slti 0x2A, sltiu 0x2B.
  - andi 0x59, ori 0x5A, xori 0x5B, lui 0x5C.
- Every output not listed for a state is 0.
- FETCH:
  - Outputs: memread = 1, alusrcb = 01, aluop = ADD.
  - `irwrite` and `pcwrite` equal `mem_ready`.
  - Next state: DECODE when `mem_ready`, else stay in FETCH.
- DECODE:
  - Outputs: alusrcb = 11, aluop = ADD (branch target into ALUOut).
  - Capture `op` into `op_q`; all later states decode `op_q`.
  - Next state by `op`:
    - 0x00 → RTEX.
    - 0x23 (lw) or 0x2B (sw) → MEMADR.
    - 0x04 (beq), and 0x05 (bne) when EN_BNE → BRANCH.
    - 0x08–0x0F → ITEX.
    - 0x02 (j), and 0x03 (jal) when EN_JAL → JUMP.
    - Anything else → ILLEGAL.
- MEMADR:
  - Outputs: alusrca = 1, alusrcb = 10, aluop = ADD.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Outputs: iord = 1, memread = 1.
  - Next state: MEMWB on `mem_ready`, else hold.
- MEMWB:
  - Outputs: regwrite = 1, regdst = 00, memtoreg = 01.
  - Next state: FETCH.
- MEMWR:
  - Outputs: iord = 1, memwrite = 1.
  - Next state: FETCH on `mem_ready`, else hold.
- RTEX:
  - Outputs: alusrca = 1, alusrcb = 00, aluop = RTYPE.
  - Next state: RTWB.
- RTWB:
  - Outputs: regwrite = 1, regdst = 01.
  - Next state: FETCH.
- ITEX:
  - Outputs: alusrca = 1, alusrcb = 10, aluop from the ALU code list.
  - ext_zero = 1 for andi, ori, xori and lui.
  - Next state: ITWB.
- ITWB:
  - Outputs: regwrite = 1, regdst = 00, memtoreg = 00.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alusrca = 1, alusrcb = 00, aluop = SUB, pcsrc = 01.
  - `branch` = 1 for beq; `branch_ne` = 1 for bne.
  - Next state: FETCH.
- JUMP:
  - Outputs: pcwrite = 1, pcsrc = 10.
  - jal additionally: regwrite = 1, regdst = 10, memtoreg = 10.
  - Next state: FETCH.
- ILLEGAL:
  - Outputs: illegal = 1, no writes.
  - Next state: FETCH. The PC has already advanced in FETCH, so execution continues at the next instruction.

## Timing
- Reset:
  - `rst` high at a clock edge sets state to FETCH and clears `op_q`.
  - While `rst` is high, every output is forced to 0, including `state` = 0.
  - The first FETCH outputs appear in the first cycle with `rst` low.
- Outputs are combinational functions of `state` and `op_q` only (Moore). `irwrite` and `pcwrite` in FETCH are the exception: they are gated by `mem_ready`.
- Instruction length with `mem_ready` tied to 1:
  - 5 cycles: lw.
  - 4 cycles: sw, R-type, I-type ALU.
  - 3 cycles: beq, bne, j, jal, illegal.
- Each cycle with `mem_ready` low in FETCH, MEMRD or MEMWR adds one cycle. The memory strobes and `iord` are held stable throughout the wait.
- `op` is sampled only in the DECODE cycle. Changes to `op` in any other cycle have no effect.
- `rst` asserted mid-instruction, including during a memory wait, aborts on that edge. No writeback or memory strobe occurs in the cycle `rst` is high.

## Structure
- Shared package `mips_ctrl_pkg.vh`:
  - Opcode constants.
  - ALU code constants.
  - State encodings: FETCH = 0 … ILLEGAL = 12.
  - Select-field encodings for `alusrcb`, `regdst`, `memtoreg` and `pcsrc`.
- One natural sub-module, `mcycle_outdec`: the combinational state/op → output table.
- The top level holds only the state register, the `op_q` register and the next-state logic.

## Test plan
- Reset then `add` (op 0x00), `mem_ready` = 1 → states 0, 1, 6, 7, 0. In RTWB: regwrite = 1, regdst = 01. aluop = 0x02 in RTEX.
- `lw` (op 0x23) with `mem_ready` low for 3 cycles in MEMRD → MEMRD lasts 4 cycles with iord = memread = 1 stable, then MEMWB with memtoreg = 01. Total 8 cycles.
- `ori` (op 0x0D) → in ITEX: aluop = 0x5A, ext_zero = 1, alusrcb = 10. ITWB then regwrite with regdst = 00.
- `bne` (op 0x05) with EN_BNE = 0 → illegal = 1 for exactly one cycle, no strobes, return to FETCH. With EN_BNE = 1 → BRANCH with branch_ne = 1, pcsrc = 01.
- `jal` (op 0x03), EN_JAL = 1 → JUMP with pcwrite = 1, regwrite = 1, regdst = 10, memtoreg = 10, pcsrc = 10.
- `rst` pulsed during MEMWR wait (memwrite = 1) → next cycle state = 0, all outputs 0. After release: FETCH, memread = 1, and no memwrite ever follows.

Source files
------------

// File: rtl/mcycle_maindec_pkg.sv
// Shared encodings for the multi-cycle MIPS main decoder: opcodes, ALU codes,
// FSM state numbering and datapath select-field values.
package mcycle_maindec_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned ALU_CODE_W = 8;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // ALU operation codes
  localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 8'h20;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 8'h22;
  localparam logic [ALU_CODE_W-1:0] ALU_RTYPE = 8'h02;
  localparam logic [ALU_CODE_W-1:0] ALU_ADDI  = 8'h08;
  localparam logic [ALU_CODE_W-1:0] ALU_ADDIU = 8'h09;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTI  = 8'h2A;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTIU = 8'h2B;
  localparam logic [ALU_CODE_W-1:0] ALU_ANDI  = 8'h59;
  localparam logic [ALU_CODE_W-1:0] ALU_ORI   = 8'h5A;
  localparam logic [ALU_CODE_W-1:0] ALU_XORI  = 8'h5B;
  localparam logic [ALU_CODE_W-1:0] ALU_LUI   = 8'h5C;

  // FSM states; numbering is visible on the debug port
  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEX    = 4'd6,
    S_RTWB    = 4'd7,
    S_ITEX    = 4'd8,
    S_ITWB    = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  // ALU B select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // Destination register select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Writeback source select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU code for the I-type ALU group 0x08..0x0F, indexed by op[2:0]
  function automatic logic [ALU_CODE_W-1:0] itype_aluop(input logic [2:0] sub);
    logic [ALU_CODE_W-1:0] code;
    case (sub)
      3'd0:    code = ALU_ADDI;
      3'd1:    code = ALU_ADDIU;
      3'd2:    code = ALU_SLTI;
      3'd3:    code = ALU_SLTIU;
      3'd4:    code = ALU_ANDI;
      3'd5:    code = ALU_ORI;
      3'd6:    code = ALU_XORI;
      default: code = ALU_LUI;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mcycle_maindec_outdec.sv
// Combinational Moore output table: state and latched opcode to datapath controls.
module mcycle_outdec
  import mcycle_maindec_pkg::*;
#(
  parameter int unsigned ALUOP_W = 8
) (
  input  logic               rst,
  input  logic [3:0]         state_q,
  input  logic [5:0]         op_q,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               irwrite,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               regwrite,
  output logic               branch,
  output logic               branch_ne,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               ext_zero,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [3:0]         state
);

  logic [ALU_CODE_W-1:0] alu_code;

  assign aluop = ALUOP_W'(alu_code);

  // Per-state control table; everything is forced low while reset is held
  always_comb begin
    pcwrite   = 1'b0;
    irwrite   = 1'b0;
    iord      = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = SRCB_RT;
    ext_zero  = 1'b0;
    regdst    = REGDST_RT;
    memtoreg  = M2R_ALUOUT;
    pcsrc     = PCSRC_ALU;
    alu_code  = '0;
    illegal   = 1'b0;
    state     = '0;
    if (!rst) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          memread  = 1'b1;
          irwrite  = mem_ready;
          pcwrite  = mem_ready;
          alusrcb  = SRCB_FOUR;
          alu_code = ALU_ADD;
        end
        S_DECODE: begin
          alusrcb  = SRCB_BRANCH;
          alu_code = ALU_ADD;
        end
        S_MEMADR: begin
          alusrca  = 1'b1;
          alusrcb  = SRCB_IMM;
          alu_code = ALU_ADD;
        end
        S_MEMRD: begin
          iord    = 1'b1;
          memread = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          regdst   = REGDST_RT;
          memtoreg = M2R_MDR;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_RTEX: begin
          alusrca  = 1'b1;
          alusrcb  = SRCB_RT;
          alu_code = ALU_RTYPE;
        end
        S_RTWB: begin
          regwrite = 1'b1;
          regdst   = REGDST_RD;
        end
        S_ITEX: begin
          alusrca  = 1'b1;
          alusrcb  = SRCB_IMM;
          alu_code = itype_aluop(op_q[2:0]);
          // andi/ori/xori/lui occupy 0x0C..0x0F
          ext_zero = op_q[2];
        end
        S_ITWB: begin
          regwrite = 1'b1;
          regdst   = REGDST_RT;
          memtoreg = M2R_ALUOUT;
        end
        S_BRANCH: begin
          alusrca   = 1'b1;
          alusrcb   = SRCB_RT;
          alu_code  = ALU_SUB;
          pcsrc     = PCSRC_ALUOUT;
          branch    = (op_q == OP_BEQ);
          branch_ne = (op_q == OP_BNE);
        end
        S_JUMP: begin
          pcwrite = 1'b1;
          pcsrc   = PCSRC_JUMP;
          if (op_q == OP_JAL) begin
            regwrite = 1'b1;
            regdst   = REGDST_RA;
            memtoreg = M2R_PC;
          end
        end
        S_ILLEGAL: begin
          illegal = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mcycle_maindec.sv
// Multi-cycle MIPS main decoder: state register, opcode latch and next-state logic.
module mcycle_maindec
  import mcycle_maindec_pkg::*;
#(
  parameter int unsigned ALUOP_W = 8,
  parameter logic        EN_JAL  = 1'b1,
  parameter logic        EN_BNE  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               irwrite,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               regwrite,
  output logic               branch,
  output logic               branch_ne,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               ext_zero,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [3:0]         state
);

  state_e          state_q;
  state_e          state_d;
  logic [OP_W-1:0] op_q;

  // State register and opcode latch; op is captured only in DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= op;
      end
    end
  end

  // Next-state logic; DECODE dispatches on the live opcode, later states on op_q
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_RTYPE)                               state_d = S_RTEX;
        else if (op == OP_LW || op == OP_SW)              state_d = S_MEMADR;
        else if (op == OP_BEQ || (EN_BNE && op == OP_BNE)) state_d = S_BRANCH;
        else if (op[5:3] == 3'b001)                       state_d = S_ITEX;
        else if (op == OP_J || (EN_JAL && op == OP_JAL))   state_d = S_JUMP;
        else                                              state_d = S_ILLEGAL;
      end
      S_MEMADR:  state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTEX:    state_d = S_RTWB;
      S_ITEX:    state_d = S_ITWB;
      S_MEMWB,
      S_RTWB,
      S_ITWB,
      S_BRANCH,
      S_JUMP,
      S_ILLEGAL: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  mcycle_outdec #(
    .ALUOP_W (ALUOP_W)
  ) u_outdec (
    .rst       (rst),
    .state_q   (state_q),
    .op_q      (op_q),
    .mem_ready (mem_ready),
    .pcwrite   (pcwrite),
    .irwrite   (irwrite),
    .iord      (iord),
    .memread   (memread),
    .memwrite  (memwrite),
    .regwrite  (regwrite),
    .branch    (branch),
    .branch_ne (branch_ne),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .ext_zero  (ext_zero),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .illegal   (illegal),
    .state     (state)
  );

endmodule

// File: tb/tb_mcycle_maindec.sv
// Cycle-by-cycle vector bench for mcycle_maindec; a second instance with
// jal/bne disabled and a wider aluop covers the illegal-decode paths.
module tb_mcycle_maindec;

  typedef struct packed {
    logic [3:0] st;
    logic [8:0] strb;   // pcwrite irwrite iord memread memwrite regwrite branch branch_ne alusrca
    logic [1:0] srcb;
    logic       ext;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic [1:0] pcs;
    logic [1:0] aop_hi;
    logic [7:0] aop;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic       r;
    logic [5:0] op;
    logic       mr;
    logic       sel;    // 0: check main instance, 1: check restricted instance
    out_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;

  logic       m_pcwrite, m_irwrite, m_iord, m_memread, m_memwrite, m_regwrite;
  logic       m_branch, m_branch_ne, m_alusrca, m_ext_zero, m_illegal;
  logic [1:0] m_alusrcb, m_regdst, m_memtoreg, m_pcsrc;
  logic [7:0] m_aluop;
  logic [3:0] m_state;

  logic       n_pcwrite, n_irwrite, n_iord, n_memread, n_memwrite, n_regwrite;
  logic       n_branch, n_branch_ne, n_alusrca, n_ext_zero, n_illegal;
  logic [1:0] n_alusrcb, n_regdst, n_memtoreg, n_pcsrc;
  logic [9:0] n_aluop;
  logic [3:0] n_state;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  mcycle_maindec #(.ALUOP_W(8), .EN_JAL(1'b1), .EN_BNE(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pcwrite(m_pcwrite), .irwrite(m_irwrite), .iord(m_iord), .memread(m_memread),
    .memwrite(m_memwrite), .regwrite(m_regwrite), .branch(m_branch),
    .branch_ne(m_branch_ne), .alusrca(m_alusrca), .alusrcb(m_alusrcb),
    .ext_zero(m_ext_zero), .regdst(m_regdst), .memtoreg(m_memtoreg),
    .pcsrc(m_pcsrc), .aluop(m_aluop), .illegal(m_illegal), .state(m_state)
  );

  mcycle_maindec #(.ALUOP_W(10), .EN_JAL(1'b0), .EN_BNE(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pcwrite(n_pcwrite), .irwrite(n_irwrite), .iord(n_iord), .memread(n_memread),
    .memwrite(n_memwrite), .regwrite(n_regwrite), .branch(n_branch),
    .branch_ne(n_branch_ne), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
    .ext_zero(n_ext_zero), .regdst(n_regdst), .memtoreg(n_memtoreg),
    .pcsrc(n_pcsrc), .aluop(n_aluop), .illegal(n_illegal), .state(n_state)
  );

  function automatic out_t got_main();
    return {m_state, m_pcwrite, m_irwrite, m_iord, m_memread, m_memwrite, m_regwrite,
            m_branch, m_branch_ne, m_alusrca, m_alusrcb, m_ext_zero, m_regdst,
            m_memtoreg, m_pcsrc, 2'b00, m_aluop, m_illegal};
  endfunction

  function automatic out_t got_nb();
    return {n_state, n_pcwrite, n_irwrite, n_iord, n_memread, n_memwrite, n_regwrite,
            n_branch, n_branch_ne, n_alusrca, n_alusrcb, n_ext_zero, n_regdst,
            n_memtoreg, n_pcsrc, n_aluop[9:8], n_aluop[7:0], n_illegal};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic m, input logic s,
                     input logic [3:0] st, input logic [8:0] strb, input logic [1:0] srcb,
                     input logic ext, input logic [1:0] rdst, input logic [1:0] m2r,
                     input logic [1:0] pcs, input logic [7:0] aop, input logic ill);
    vec_t v;
    v.r = r; v.op = o; v.mr = m; v.sel = s;
    v.e = '{st: st, strb: strb, srcb: srcb, ext: ext, rdst: rdst, m2r: m2r,
            pcs: pcs, aop_hi: 2'b00, aop: aop, ill: ill};
    vq.push_back(v);
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic m);
    @(negedge clk);
    rst = r; op = o; mem_ready = m;
    #1;
  endtask

  task automatic check_bits(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    out_t g;
    rst = 1'b1; op = '0; mem_ready = 1'b1;

    //   r  op     mr s  st  strb          srcb  e rdst  m2r   pcs   aop    ill
    add(1, 6'h00, 1, 0, 0,  9'b000000000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0); // reset
    add(1, 6'h00, 1, 0, 0,  9'b000000000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    // add: 0,1,6,7
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h3F, 1, 0, 6,  9'b000000001, 2'b00,0,2'b00,2'b00,2'b00,8'h02, 0);
    add(0, 6'h3F, 1, 0, 7,  9'b000001000, 2'b00,0,2'b01,2'b00,2'b00,8'h00, 0);
    // lw with three wait cycles in MEMRD
    add(0, 6'h23, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h23, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h2B, 1, 0, 2,  9'b000000001, 2'b10,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h2B, 0, 0, 3,  9'b001100000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    add(0, 6'h2B, 0, 0, 3,  9'b001100000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    add(0, 6'h2B, 0, 0, 3,  9'b001100000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    add(0, 6'h2B, 1, 0, 3,  9'b001100000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    add(0, 6'h2B, 1, 0, 4,  9'b000001000, 2'b00,0,2'b00,2'b01,2'b00,8'h00, 0);
    // ori, with one fetch wait
    add(0, 6'h0D, 0, 0, 0,  9'b000100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h0D, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h0D, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 8,  9'b000000001, 2'b10,1,2'b00,2'b00,2'b00,8'h5A, 0);
    add(0, 6'h00, 1, 0, 9,  9'b000001000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    // bne on the full decoder
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h05, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 10, 9'b000000011, 2'b00,0,2'b00,2'b00,2'b01,8'h22, 0);
    // jal on the full decoder
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h03, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 11, 9'b100001000, 2'b00,0,2'b10,2'b10,2'b10,8'h00, 0);
    // bne then jal on the restricted decoder: one-cycle illegal each
    add(0, 6'h00, 1, 1, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h05, 1, 1, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 1, 12, 9'b000000000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 1);
    add(0, 6'h00, 1, 1, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h03, 1, 1, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 1, 12, 9'b000000000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 1);
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    // beq
    add(0, 6'h04, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 10, 9'b000000101, 2'b00,0,2'b00,2'b00,2'b01,8'h22, 0);
    // unknown opcode
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h3F, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 12, 9'b000000000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 1);
    // j
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h02, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 11, 9'b100000000, 2'b00,0,2'b00,2'b00,2'b10,8'h00, 0);
    // sltiu
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h0B, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 8,  9'b000000001, 2'b10,0,2'b00,2'b00,2'b00,8'h2B, 0);
    add(0, 6'h00, 1, 0, 9,  9'b000001000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    // sw aborted by reset during the memory wait
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h2B, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 2,  9'b000000001, 2'b10,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 0, 0, 5,  9'b001010000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    add(0, 6'h00, 0, 0, 5,  9'b001010000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    add(1, 6'h00, 0, 0, 0,  9'b000000000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);
    add(0, 6'h00, 0, 0, 0,  9'b000100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 6,  9'b000000001, 2'b00,0,2'b00,2'b00,2'b00,8'h02, 0);
    add(0, 6'h00, 1, 0, 7,  9'b000001000, 2'b00,0,2'b01,2'b00,2'b00,8'h00, 0);
    // lui: top of the I-type range
    add(0, 6'h00, 1, 0, 0,  9'b110100000, 2'b01,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h0F, 1, 0, 1,  9'b000000000, 2'b11,0,2'b00,2'b00,2'b00,8'h20, 0);
    add(0, 6'h00, 1, 0, 8,  9'b000000001, 2'b10,1,2'b00,2'b00,2'b00,8'h5C, 0);
    add(0, 6'h00, 1, 0, 9,  9'b000001000, 2'b00,0,2'b00,2'b00,2'b00,8'h00, 0);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].op, vq[i].mr);
      g = vq[i].sel ? got_nb() : got_main();
      n_checks++;
      if (g !== vq[i].e) begin
        n_fail++;
        $display("FAIL vec%0d st=%0d got=%h exp=%h", i, g.st, g, vq[i].e);
      end
    end

    // sw with a two-cycle write wait: strobes hold, then one FETCH and no more writes
    step(0, 6'h2B, 1);
    check_bits("sw_fetch_state", 8'(m_state), 8'd0);
    step(0, 6'h2B, 1);
    step(0, 6'h00, 1);
    for (int k = 0; k < 2; k++) begin
      step(0, 6'h00, 0);
      check_bits("sw_wait", {m_state, m_iord, m_memwrite, m_memread, m_regwrite}, 8'h5C);
    end
    step(0, 6'h00, 1);
    check_bits("sw_done", {m_state, m_iord, m_memwrite, m_memread, m_regwrite}, 8'h5C);
    step(0, 6'h00, 0);
    check_bits("sw_back", {m_state, m_iord, m_memwrite, m_memread, m_regwrite}, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
